// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the arbitrated UART transmitter.
//   tx_state_t   : transmitter FSM state encoding
//   bit_count()  : last value of the bit-period counter for a clock/baud pair
//   MCLK_DEFAULT : default system clock frequency in Hz
//   BAUD_DEFAULT : default line rate in bits/s
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int MCLK_DEFAULT = 100_000_000;
   localparam int BAUD_DEFAULT = 115_200;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;
`endif

   // One bit lasts bit_count()+1 clock cycles.
   function automatic int bit_count(input int mclk, input int baud);
      return (mclk / baud) - 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Grants the first requesting index strictly after the
// last granted one, wrapping from N-1 to 0. After reset index 0 has highest
// priority.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req          : request vector
//   en           : grant enable; no grant and no pointer update when low
//   gnt          : one-hot grant, combinational in the enabled cycle
//   idx          : index of the selected requester (valid when any req set)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] last_q;
   logic          found;
   int            k;

   always_comb begin
      // NOTE: every variable written here gets a value before any branch, so
      // no path leaves one unassigned and no latch is inferred.
      gnt   = '0;
      idx   = last_q;
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
         k = int'(last_q) + i;
         if (k >= N) k = k - N;
         if (!found && req[IW'(k)]) begin
            found = 1'b1;
            idx   = IW'(k);
         end
      end
      if (en && found) gnt[idx] = 1'b1;
   end

   // Pointer starts at N-1 so the search after reset begins at index 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of the order of clocked processes.
      if (rst_i)             last_q <= IW'(N - 1);
      else if (en && found)  last_q <= idx;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX line between NREQ byte requesters. A round-robin arbiter
// picks a requester while idle, its byte is latched and sent as
// start bit, DATA_BITS data bits LSB first, [parity], one stop bit.
// The bit-period counter restarts at each frame, so bit timing is aligned to
// the frame start.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset (aborts a frame in flight)
//   req_i   : per-requester request level, held with data until granted
//   data_i  : requester k's byte at [k*DATA_BITS +: DATA_BITS]
//   gnt_o   : one-hot, 1-cycle pulse: byte of that requester accepted
//   owner_o : index of the last granted requester
//   busy_o  : high while a frame is on the line
//   tx_o    : serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int MCLK      = MCLK_DEFAULT,
   parameter int BAUD      = BAUD_DEFAULT,
   parameter int NREQ      = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ*DATA_BITS-1:0] data_i,
   output logic [NREQ-1:0]           gnt_o,
   output logic [$clog2(NREQ)-1:0]   owner_o,
   output logic                      busy_o,
   output logic                      tx_o
);

   localparam int BIT_CNT = bit_count(MCLK, BAUD);
   localparam int CW      = $clog2(BIT_CNT + 1);
   localparam int IW      = $clog2(NREQ);
   localparam int BW      = $clog2(DATA_BITS);

   tx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [IW-1:0]        owner_q;
`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`endif

   logic                 arb_en;
   logic [NREQ-1:0]      arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 grant;
   logic                 bit_end;
   logic                 last_bit;
   logic [DATA_BITS-1:0] data_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign data_arr[g] = data_i[g*DATA_BITS +: DATA_BITS];
   end

   // Reset gates the enable so no grant can leak out while rst_i is held.
   assign arb_en   = (state_q == IDLE) && !rst_i;
   assign grant    = |arb_gnt;
   assign bit_end  = (cnt_q == CW'(BIT_CNT));
   assign last_bit = (bit_q == BW'(DATA_BITS - 1));

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req   (req_i),
      .en    (arb_en),
      .gnt   (arb_gnt),
      .idx   (arb_idx)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (grant)   state_d = START;
         START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (bit_end && last_bit) state_d = PARITY;
         PARITY: if (bit_end) state_d = STOP;
`else
         DATA:   if (bit_end && last_bit) state_d = STOP;
`endif
         STOP:   if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode straight from the state register, so reset forces the
   // line high in the same cycle.
   always_comb begin
      tx_o   = 1'b1;
      busy_o = 1'b1;
      unique case (state_q)
         IDLE:   busy_o = 1'b0;
         START:  tx_o   = 1'b0;
         DATA:   tx_o   = shift_q[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_o   = par_q;
`endif
         STOP:   tx_o   = 1'b1;
         default: begin
            tx_o   = 1'b1;
            busy_o = 1'b0;
         end
      endcase
   end

   // Datapath: byte latch, bit-period counter, bit index.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the shift register is only observed after a load, but it is
         // reset anyway so tx_o never carries X in simulation.
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         owner_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (grant) begin
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= data_arr[arb_idx];
         owner_q <= arb_idx;
`ifdef UART_TX_PARITY_EN
         par_q   <= ^data_arr[arb_idx];
`endif
      end else if (state_q != IDLE) begin
         if (bit_end) begin
            cnt_q <= '0;
            if (state_q == DATA) begin
               shift_q <= shift_q >> 1;
               bit_q   <= bit_q + BW'(1);
            end
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign gnt_o   = arb_gnt;
   assign owner_o = owner_q;

endmodule
